channel_err_inj: RTL and testbench

CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

---
 rtl/channel_err_inj.sv | 79 +++++++
 tb/tb_channel_err_inj.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_err_inj.sv
// channel_err_inj: corrupts encoder symbols in periodic bursts or pseudo-randomly and keeps error statistics (random mode built only with CHAN_ERR_LFSR_EN)
module channel_err_inj #(
  parameter int W = 2,
  parameter int PERIOD = 32,
  parameter int BURST = 4,
  parameter logic [W-1:0] MASK = W'(2'b10),
  parameter int WINDOW = 256,
  parameter int THRESH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] sym_i,
  input  logic [1:0]   mode_i,
  input  logic         clear_i,
  output logic         valid_o,
  output logic [W-1:0] sym_o,
  output logic         err_o,
  output logic [15:0]  bad_bit_ct_o,
  output logic [15:0]  word_ct_o
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int PC = $countones(MASK);
  logic [CW-1:0] err_cnt;
  logic          accept;
  logic          burst_hit;
  logic          rand_hit;
  logic          corrupt;
  logic          in_window;
  logic [16:0]   bad_sum;
  assign accept    = valid_i & ~clear_i;
  assign burst_hit = mode_i == 2'b01 && 32'(err_cnt) >= 32'(PERIOD - BURST);
  assign corrupt   = accept & (burst_hit | rand_hit);
  assign in_window = 32'(word_ct_o) < 32'(WINDOW);
  assign bad_sum   = {1'b0, bad_bit_ct_o} + 17'(PC);
`ifdef CHAN_ERR_LFSR_EN
  logic [15:0] lfsr;
  assign rand_hit = mode_i == 2'b10 && {1'b0, lfsr[7:0]} < 9'(THRESH);
  // Fibonacci LFSR (taps 16,14,13,11): reseeded by reset or clear, one step per accepted symbol
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else if (clear_i) lfsr <= 16'hACE1;
    else if (valid_i) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  assign rand_hit = 1'b0;
`endif
  // Output stage: one cycle latency, symbol and error flag forced low on idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      sym_o   <= '0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= valid_i;
      sym_o   <= valid_i ? sym_i ^ (corrupt ? MASK : '0) : '0;
      err_o   <= corrupt;
    end
  end
  // Burst phase advances on every accepted symbol regardless of mode so switching keeps the phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt <= '0;
    else if (clear_i) err_cnt <= '0;
    else if (valid_i) err_cnt <= err_cnt == CW'(PERIOD - 1) ? '0 : err_cnt + 1'b1;
  end
  // Statistics only accumulate while the accepted-symbol window is still open
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_ct_o    <= '0;
      bad_bit_ct_o <= '0;
    end else if (clear_i) begin
      word_ct_o    <= '0;
      bad_bit_ct_o <= '0;
    end else if (valid_i && in_window) begin
      word_ct_o    <= word_ct_o + 1'b1;
      bad_bit_ct_o <= corrupt ? (bad_sum[16] ? 16'hFFFF : bad_sum[15:0]) : bad_bit_ct_o;
    end
  end
endmodule

// File: tb/tb_channel_err_inj.sv
// tb_channel_err_inj: directed checks of burst, idle, window, clear, random-mode and reset behaviour
module tb_channel_err_inj;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = '0;
  logic [1:0]  mode_i = '0;
  logic        clear_i = 1'b0;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic        err_o;
  logic [15:0] bad_bit_ct_o;
  logic [15:0] word_ct_o;
  int vecs = 0;
  int fails = 0;

  channel_err_inj dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i), .clear_i(clear_i),
    .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o), .bad_bit_ct_o(bad_bit_ct_o), .word_ct_o(word_ct_o)
  );

`ifdef CHAN_ERR_LFSR_EN
  logic        v0, v1, e0, e1;
  logic [1:0]  s0, s1;
  logic [15:0] b0, b1, w0, w1;
  channel_err_inj #(.THRESH(0)) dut_t0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i), .clear_i(clear_i),
    .valid_o(v0), .sym_o(s0), .err_o(e0), .bad_bit_ct_o(b0), .word_ct_o(w0)
  );
  channel_err_inj #(.THRESH(256)) dut_t256 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i), .clear_i(clear_i),
    .valid_o(v1), .sym_o(s1), .err_o(e1), .bad_bit_ct_o(b1), .word_ct_o(w1)
  );
`endif

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [1:0] s, input logic [1:0] m, input logic c);
    valid_i = v;
    sym_i   = s;
    mode_i  = m;
    clear_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    @(posedge clk);
    #1;
    vecs++;
    if ({valid_o, sym_o, err_o} !== 4'b0 || bad_bit_ct_o !== 16'd0 || word_ct_o !== 16'd0) begin
      fails++;
      $display("FAIL reset: valid=%b sym=%b err=%b bad=%0d word=%0d, want all 0", valid_o, sym_o, err_o, bad_bit_ct_o, word_ct_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_burst;
    for (int k = 0; k < 64; k++) begin
      logic [1:0] s;
      logic e;
      s = 2'(k * 3);
      e = (k % 32) >= 28;
      step(1'b1, s, 2'b01, 1'b0);
      vecs++;
      if (valid_o !== 1'b1 || err_o !== e || sym_o !== (s ^ (e ? 2'b10 : 2'b00))) begin
        fails++;
        $display("FAIL burst sym %0d: valid=%b err=%b sym=%b, want 1 %b %b", k, valid_o, err_o, sym_o, e, s ^ (e ? 2'b10 : 2'b00));
      end
    end
    vecs++;
    if (bad_bit_ct_o !== 16'd8 || word_ct_o !== 16'd64) begin
      fails++;
      $display("FAIL burst counts: bad=%0d word=%0d, want 8 64", bad_bit_ct_o, word_ct_o);
    end
    step(1'b0, 2'b00, 2'b01, 1'b1);
    vecs++;
    if (bad_bit_ct_o !== 16'd0 || word_ct_o !== 16'd0 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL clear idle: bad=%0d word=%0d valid=%b, want 0 0 0", bad_bit_ct_o, word_ct_o, valid_o);
    end
  endtask

  task automatic test_toggle;
    for (int k = 0; k < 32; k++) begin
      logic [1:0] s;
      logic e;
      s = 2'(k);
      e = k >= 28;
      step(1'b1, s, 2'b01, 1'b0);
      vecs++;
      if (valid_o !== 1'b1 || err_o !== e || sym_o !== (s ^ (e ? 2'b10 : 2'b00))) begin
        fails++;
        $display("FAIL toggle sym %0d: valid=%b err=%b sym=%b, want 1 %b %b", k, valid_o, err_o, sym_o, e, s ^ (e ? 2'b10 : 2'b00));
      end
      step(1'b0, 2'b11, 2'b01, 1'b0);
      vecs++;
      if (valid_o !== 1'b0 || err_o !== 1'b0 || sym_o !== 2'b00) begin
        fails++;
        $display("FAIL toggle idle %0d: valid=%b err=%b sym=%b, want 0 0 00", k, valid_o, err_o, sym_o);
      end
    end
    vecs++;
    if (bad_bit_ct_o !== 16'd4 || word_ct_o !== 16'd32) begin
      fails++;
      $display("FAIL toggle counts: bad=%0d word=%0d, want 4 32", bad_bit_ct_o, word_ct_o);
    end
    step(1'b0, 2'b00, 2'b00, 1'b1);
  endtask

  task automatic test_window;
    for (int k = 0; k < 300; k++) step(1'b1, 2'(k), 2'b01, 1'b0);
    vecs++;
    if (word_ct_o !== 16'd256 || bad_bit_ct_o !== 16'd32) begin
      fails++;
      $display("FAIL window 300: word=%0d bad=%0d, want 256 32", word_ct_o, bad_bit_ct_o);
    end
    for (int k = 300; k < 320; k++) step(1'b1, 2'(k), 2'b01, 1'b0);
    vecs++;
    if (word_ct_o !== 16'd256 || bad_bit_ct_o !== 16'd32) begin
      fails++;
      $display("FAIL window hold: word=%0d bad=%0d, want 256 32", word_ct_o, bad_bit_ct_o);
    end
    step(1'b0, 2'b00, 2'b00, 1'b1);
  endtask

  task automatic test_phase;
    for (int k = 0; k < 33; k++) begin
      logic [1:0] m;
      logic e;
      m = (k >= 28 && k < 32) ? 2'b01 : 2'b00;
      e = k >= 28 && k < 32;
      step(1'b1, 2'b00, m, 1'b0);
      vecs++;
      if (err_o !== e || sym_o !== (e ? 2'b10 : 2'b00)) begin
        fails++;
        $display("FAIL phase sym %0d: err=%b sym=%b, want %b %b", k, err_o, sym_o, e, e ? 2'b10 : 2'b00);
      end
    end
    step(1'b0, 2'b00, 2'b00, 1'b1);
  endtask

  task automatic test_clear;
    for (int k = 0; k < 29; k++) step(1'b1, 2'(k), 2'b01, 1'b0);
    step(1'b1, 2'b11, 2'b01, 1'b1);
    vecs++;
    if (valid_o !== 1'b1 || err_o !== 1'b0 || sym_o !== 2'b11 || word_ct_o !== 16'd0 || bad_bit_ct_o !== 16'd0) begin
      fails++;
      $display("FAIL clear sym 29: valid=%b err=%b sym=%b word=%0d bad=%0d, want 1 0 11 0 0", valid_o, err_o, sym_o, word_ct_o, bad_bit_ct_o);
    end
    for (int k = 0; k < 32; k++) begin
      logic e;
      e = k >= 28;
      step(1'b1, 2'b01, 2'b01, 1'b0);
      vecs++;
      if (err_o !== e || sym_o !== (e ? 2'b11 : 2'b01)) begin
        fails++;
        $display("FAIL post-clear sym %0d: err=%b sym=%b, want %b %b", k, err_o, sym_o, e, e ? 2'b11 : 2'b01);
      end
    end
    vecs++;
    if (bad_bit_ct_o !== 16'd4 || word_ct_o !== 16'd32) begin
      fails++;
      $display("FAIL post-clear counts: bad=%0d word=%0d, want 4 32", bad_bit_ct_o, word_ct_o);
    end
    step(1'b0, 2'b00, 2'b00, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 32; k++) begin
      logic [1:0] s;
      s = 2'(k);
      step(1'b1, s, 2'b10, 1'b0);
`ifdef CHAN_ERR_LFSR_EN
      vecs++;
      if (e0 !== 1'b0 || s0 !== s || e1 !== 1'b1 || s1 !== (s ^ 2'b10)) begin
        fails++;
        $display("FAIL random sym %0d: t0 err=%b sym=%b t256 err=%b sym=%b, want 0 %b 1 %b", k, e0, s0, e1, s1, s, s ^ 2'b10);
      end
`else
      vecs++;
      if (err_o !== 1'b0 || sym_o !== s) begin
        fails++;
        $display("FAIL random-off sym %0d: err=%b sym=%b, want 0 %b", k, err_o, sym_o, s);
      end
`endif
    end
`ifdef CHAN_ERR_LFSR_EN
    vecs++;
    if (b0 !== 16'd0 || b1 !== 16'd32) begin
      fails++;
      $display("FAIL random counts: t0 bad=%0d t256 bad=%0d, want 0 32", b0, b1);
    end
`else
    vecs++;
    if (bad_bit_ct_o !== 16'd0 || word_ct_o !== 16'd32) begin
      fails++;
      $display("FAIL random-off counts: bad=%0d word=%0d, want 0 32", bad_bit_ct_o, word_ct_o);
    end
`endif
    step(1'b0, 2'b00, 2'b00, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 31; k++) step(1'b1, 2'b01, 2'b01, 1'b0);
    vecs++;
    if (err_o !== 1'b1 || sym_o !== 2'b11 || bad_bit_ct_o !== 16'd3) begin
      fails++;
      $display("FAIL pre-reset sym 30: err=%b sym=%b bad=%0d, want 1 11 3", err_o, sym_o, bad_bit_ct_o);
    end
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if ({valid_o, sym_o, err_o} !== 4'b0 || bad_bit_ct_o !== 16'd0 || word_ct_o !== 16'd0) begin
      fails++;
      $display("FAIL async reset: valid=%b sym=%b err=%b bad=%0d word=%0d, want all 0", valid_o, sym_o, err_o, bad_bit_ct_o, word_ct_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 32; k++) begin
      logic e;
      e = k >= 28;
      step(1'b1, 2'b01, 2'b01, 1'b0);
      vecs++;
      if (err_o !== e || sym_o !== (e ? 2'b11 : 2'b01)) begin
        fails++;
        $display("FAIL post-reset sym %0d: err=%b sym=%b, want %b %b", k, err_o, sym_o, e, e ? 2'b11 : 2'b01);
      end
    end
  endtask

  initial begin
    test_reset;
    test_burst;
    test_toggle;
    test_window;
    test_phase;
    test_clear;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
